// File: rtl/register_nbits_mod.sv
// register_nbits_mod
//   A WIDTH-bit storage register that can parallel-load, count up modulo
//   MODULUS, or hold. Carry is a registered one-cycle pulse that marks a
//   wrap on the previous edge, so it can drive the next stage's Inc
//   (for example, the mod-10 / mod-6 digit pairs of the alarm clock).
//
//   Optional build macro: REGISTER_COUNT_DOWN_EN
//     When defined, a Down input is added after Inc. Inc=1 with Down=1
//     counts down, and a 0 -> MODULUS-1 wrap pulses Carry as a borrow.
//
// Parameters
//   WIDTH    register width in bits (1..16)
//   MODULUS  count modulus (2..2**WIDTH); Q counts 0..MODULUS-1
//
// Ports
//   Clock   rising-edge clock
//   Clear   asynchronous active-low reset (Q=0, Carry=0)
//   Enable  1 = update on this edge, 0 = hold (Carry drops to 0)
//   Load    parallel load of D; out-of-range D loads 0
//   Inc     count by one when Load=0
//   Down    (REGISTER_COUNT_DOWN_EN only) count direction for Inc
//   D       parallel load data
//   Q       stored value
//   Q_n     combinational ~Q
//   Carry   registered wrap / borrow pulse
module register_nbits_mod #(
  parameter int WIDTH   = 2,
  parameter int MODULUS = 4
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Enable,
  input  logic             Load,
  input  logic             Inc,
`ifdef REGISTER_COUNT_DOWN_EN
  input  logic             Down,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n,
  output logic             Carry
);

  // Comparisons use WIDTH+1 bits so that MODULUS = 2**WIDTH is representable.
  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_W = MOD_W - 1'b1;

  // Elaboration-time guard against an illegal configuration.
  if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_cfg
    initial begin
      $display("register_nbits_mod: illegal configuration WIDTH=%0d MODULUS=%0d",
               WIDTH, MODULUS);
      $finish;
    end
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             d_in_range;
  logic             at_top;
  logic             count_down;

  assign d_in_range = ({1'b0, D} < MOD_W);
  // ">=" rather than "==" also folds any unreachable out-of-range Q back to 0.
  assign at_top     = ({1'b0, q_q} >= MAX_W);

`ifdef REGISTER_COUNT_DOWN_EN
  assign count_down = Down;
`else
  assign count_down = 1'b0;
`endif

  always_comb begin
    q_d     = q_q;
    carry_d = 1'b0;
    if (Enable) begin
      if (Load) begin
        q_d = d_in_range ? D : '0;
      end else if (Inc) begin
        if (count_down) begin
          if (q_q == '0) begin
            q_d     = MAX_W[WIDTH-1:0];
            carry_d = 1'b1;
          end else begin
            q_d = q_q - WIDTH'(1);
          end
        end else begin
          if (at_top) begin
            q_d     = '0;
            carry_d = 1'b1;
          end else begin
            q_d = q_q + WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      q_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
    end
  end

  assign Q     = q_q;
  assign Q_n   = ~q_q;
  assign Carry = carry_q;

endmodule

// File: tb/tb_register_nbits_mod.sv
// Bench for register_nbits_mod. Three instances (4-bit mod-10, 3-bit mod-6,
// default 2-bit mod-4) share one control stream; each has its own reference
// model built from the counting rules with plain integer arithmetic.
module tb_register_nbits_mod;

`ifdef REGISTER_COUNT_DOWN_EN
  localparam bit HAS_DOWN = 1'b1;
`else
  localparam bit HAS_DOWN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear;
  logic       en, ld, inc, dn;
  logic [3:0] d;

  logic [3:0] q4, qn4;
  logic [2:0] q3, qn3;
  logic [1:0] q2, qn2;
  logic       c4, c3, c2;

  register_nbits_mod #(.WIDTH(4), .MODULUS(10)) u4 (
    .Clock(clk), .Clear(clear), .Enable(en), .Load(ld), .Inc(inc),
`ifdef REGISTER_COUNT_DOWN_EN
    .Down(dn),
`endif
    .D(d), .Q(q4), .Q_n(qn4), .Carry(c4));

  register_nbits_mod #(.WIDTH(3), .MODULUS(6)) u3 (
    .Clock(clk), .Clear(clear), .Enable(en), .Load(ld), .Inc(inc),
`ifdef REGISTER_COUNT_DOWN_EN
    .Down(dn),
`endif
    .D(d[2:0]), .Q(q3), .Q_n(qn3), .Carry(c3));

  register_nbits_mod u2 (
    .Clock(clk), .Clear(clear), .Enable(en), .Load(ld), .Inc(inc),
`ifdef REGISTER_COUNT_DOWN_EN
    .Down(dn),
`endif
    .D(d[1:0]), .Q(q2), .Q_n(qn2), .Carry(c2));

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model state.
  int m4, m3, m2;
  int mc4, mc3, mc2;

  function automatic void model_next(input int modulus, input int q,
                                     input logic e, input logic l, input logic i,
                                     input logic down, input int dv,
                                     output int nq, output int nc);
    nq = q;
    nc = 0;
    if (!e) begin
      nq = q;
    end else if (l) begin
      nq = (dv < modulus) ? dv : 0;
    end else if (i) begin
      if (HAS_DOWN && down) begin
        if (q == 0) begin nq = modulus - 1; nc = 1; end
        else        begin nq = q - 1; end
      end else begin
        if (q + 1 >= modulus) begin nq = 0; nc = 1; end
        else                  begin nq = q + 1; end
      end
    end
  endfunction

  task automatic model_reset();
    m4 = 0; m3 = 0; m2 = 0;
    mc4 = 0; mc3 = 0; mc2 = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, " u4.Q"},     int'(q4),  m4);
    check({tag, " u4.Q_n"},   int'(qn4), (~m4) & 15);
    check({tag, " u4.Carry"}, int'(c4),  mc4);
    check({tag, " u3.Q"},     int'(q3),  m3);
    check({tag, " u3.Q_n"},   int'(qn3), (~m3) & 7);
    check({tag, " u3.Carry"}, int'(c3),  mc3);
    check({tag, " u2.Q"},     int'(q2),  m2);
    check({tag, " u2.Q_n"},   int'(qn2), (~m2) & 3);
    check({tag, " u2.Carry"}, int'(c2),  mc2);
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit
  // after the edge that consumes them.
  task automatic apply(input logic e, input logic l, input logic i,
                       input logic down, input logic [3:0] dv, input string tag);
    int n;
    int c;
    en = e; ld = l; inc = i; dn = down; d = dv;
    @(posedge clk);
    model_next(10, m4, e, l, i, down, int'(dv),       n, c); m4 = n; mc4 = c;
    model_next(6,  m3, e, l, i, down, int'(dv) & 7,   n, c); m3 = n; mc3 = c;
    model_next(4,  m2, e, l, i, down, int'(dv) & 3,   n, c); m2 = n; mc2 = c;
    #1;
    compare_all(tag);
  endtask

  // ---------------- vector table (4-bit mod-10 expectations) ----------------
  typedef struct {
    logic       en;
    logic       ld;
    logic       inc;
    logic [3:0] d;
    logic [3:0] exp_q;
    logic       exp_c;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0}; // disabled: hold at 0
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'd7,  4'd7, 1'b0}; // load 7
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'd0,  4'd8, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'd0,  4'd9, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'd0,  4'd0, 1'b1}; // wrap 9 -> 0
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'd0,  4'd1, 1'b0}; // pulse lasts one cycle
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'd12, 4'd0, 1'b0}; // out-of-range load
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'd3,  4'd3, 1'b0}; // Load beats Inc
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd3, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd3, 1'b0}; // enabled, idle
    vecs[11] = '{1'b1, 1'b1, 1'b0, 4'd9,  4'd9, 1'b0}; // top legal value
  end

  // ---------------- main sequence ----------------
  initial begin
    clear = 1'b0; en = 1'b0; ld = 1'b0; inc = 1'b1; dn = 1'b0; d = '0;
    model_reset();
    #9;
    compare_all("reset");
    #1 clear = 1'b1;  // t=10, first active edge at t=15

    // Table vectors.
    for (int k = 0; k < 12; k++) begin
      apply(vecs[k].en, vecs[k].ld, vecs[k].inc, 1'b0, vecs[k].d, $sformatf("vec%0d", k));
      check($sformatf("vec%0d tbl.Q", k),     int'(q4), int'(vecs[k].exp_q));
      check($sformatf("vec%0d tbl.Carry", k), int'(c4), int'(vecs[k].exp_c));
    end

    // Mod-6: count to 4, stall two edges, resume through the wrap.
    apply(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "m6 load0");
    for (int k = 0; k < 4; k++) apply(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, "m6 up");
    check("m6 at4", int'(q3), 4);
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, "m6 stall");
      check("m6 stall Q", int'(q3), 4);
      check("m6 stall Carry", int'(c3), 0);
    end
    apply(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, "m6 to5");
    check("m6 to5", int'(q3), 5);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, "m6 wrap");
    check("m6 wrap Q", int'(q3), 0);
    check("m6 wrap Carry", int'(c3), 1);

    // Asynchronous clear between edges at Q=3.
    for (int k = 0; k < 3; k++) apply(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, "m6 pre");
    check("m6 at3", int'(q3), 3);
    #2 clear = 1'b0;
    model_reset();
    #1;
    compare_all("async clear");
    check("async u3.Q", int'(q3), 0);
    #1 clear = 1'b1;

    // Legacy 2-bit sequence on the default instance.
    apply(1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, "legacy d01");
    check("legacy Q01", int'(q2), 1);
    check("legacy Qn10", int'(qn2), 2);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 4'b0011, "legacy d11");
    check("legacy Q11", int'(q2), 3);
    check("legacy Qn00", int'(qn2), 0);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "legacy wrap");
    check("legacy wrap Q", int'(q2), 0);
    check("legacy wrap Carry", int'(c2), 1);

`ifdef REGISTER_COUNT_DOWN_EN
    // Count down through zero on the mod-10 instance.
    apply(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, "down load1");
    apply(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, "down to0");
    check("down to0 Q", int'(q4), 0);
    check("down to0 Carry", int'(c4), 0);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, "down borrow");
    check("down borrow Q", int'(q4), 9);
    check("down borrow Carry", int'(c4), 1);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, "down ignored on load");
    check("down load Q", int'(q4), 5);
`else
    // Up-only build: the same idea counts up instead.
    apply(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, "up load1");
    apply(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, "up to2");
    check("up to2 Q", int'(q4), 2);
`endif

    // Randomized stimulus against the reference models.
    for (int k = 0; k < 400; k++) begin
      apply(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
